gcd_lcm_ctrl: RTL and testbench

Sequencing controller for the shared 32-bit ALU inside the GCD/LCM coprocessor.
- Accepts two unsigned operands and a mode bit.
- Drives the ALU's a/b/op inputs cycle by cycle and reads back y/z.
  - GCD by Euclid subtraction.
  - LCM by stepping multiples with addition.
- Returns the result with a start/busy/done handshake to the RISC-V-side interface logic.

---
 rtl/gcd_lcm_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gcd_lcm_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_ctrl.sv
// Sequencer for the shared ALU in the GCD/LCM coprocessor. It computes GCD by
// Euclid subtraction and LCM by stepping multiples, one ALU operation per cycle.
module gcd_lcm_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z
);

  localparam int            IW         = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);
  localparam logic [2:0]    OP_ADD     = 3'b000;
  localparam logic [2:0]    OP_SUB     = 3'b001;
  localparam logic [2:0]    OP_SLT     = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_EQ   = 3'd2,
    S_LT   = 3'd3,
    S_UPD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              m_q, m_d, lt_q, lt_d, err_q, err_d;
  logic [IW-1:0]     iter_q, iter_d, iter_inc;
  logic              ovf;

  // Handshake: start is sampled only in IDLE; busy is high from the cycle after
  // acceptance through DONE; done pulses for the single DONE cycle, and
  // result/err are valid from done until the next accepted start.
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign err    = err_q;

  assign iter_inc = iter_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    m_d      = m_q;
    lt_d     = lt_q;
    iter_d   = iter_q;
    result_d = result_q;
    err_d    = err_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_ADD;
    ovf      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = op_a;
          sa_d    = op_a;
          y_d     = op_b;
          sb_d    = op_b;
          m_d     = mode;
          iter_d  = '0;
          err_d   = 1'b0;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if ((x_q == '0) || (y_q == '0)) begin
          result_d = m_q ? '0 : (x_q | y_q);
          state_d  = S_DONE;
        end else begin
          state_d = S_EQ;
        end
      end
      S_EQ: begin
        alu_a  = x_q;
        alu_b  = y_q;
        alu_op = OP_SUB;
        if (alu_z) begin
          result_d = x_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_LT;
        end
      end
      S_LT: begin
        alu_a   = x_q;
        alu_b   = y_q;
        alu_op  = OP_SLT;
        lt_d    = alu_y[0];
        state_d = S_UPD;
      end
      S_UPD: begin
        iter_d = iter_inc;
        if (!m_q) begin
          alu_op = OP_SUB;
          if (lt_q) begin
            alu_a = y_q;
            alu_b = x_q;
            y_d   = alu_y;
          end else begin
            alu_a = x_q;
            alu_b = y_q;
            x_d   = alu_y;
          end
        end else begin
          // An unsigned add wrapped exactly when the sum is below the addend.
          alu_op = OP_ADD;
          if (lt_q) begin
            alu_a = x_q;
            alu_b = sa_q;
            x_d   = alu_y;
            ovf   = (alu_y < sa_q);
          end else begin
            alu_a = y_q;
            alu_b = sb_q;
            y_d   = alu_y;
            ovf   = (alu_y < sb_q);
          end
        end
        if (ovf || (iter_inc == ITER_LIMIT)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          state_d = S_EQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      m_q      <= 1'b0;
      lt_q     <= 1'b0;
      iter_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      m_q      <= m_d;
      lt_q     <= lt_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gcd_lcm_ctrl.sv
// Bench for gcd_lcm_ctrl: two instances (default and MAX_ITER=4) each closed
// over a behavioural ALU; results are checked against an arithmetic GCD/LCM model.
module tb_gcd_lcm_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start0, start1, mode;
  logic [31:0] op_a, op_b;

  logic        busy0, done0, err0, alu_z0;
  logic [31:0] result0, alu_a0, alu_b0, alu_y0;
  logic [2:0]  alu_op0;
  logic        busy1, done1, err1, alu_z1;
  logic [31:0] result1, alu_a1, alu_b1, alu_y1;
  logic [2:0]  alu_op1;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] trace_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_y0 = alu_f(alu_a0, alu_b0, alu_op0);
  assign alu_z0 = (alu_y0 == 32'd0);
  assign alu_y1 = alu_f(alu_a1, alu_b1, alu_op1);
  assign alu_z1 = (alu_y1 == 32'd0);

  gcd_lcm_ctrl #(.WIDTH(32), .MAX_ITER(65535)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode),
    .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0), .result(result0),
    .err(err0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
    .alu_y(alu_y0), .alu_z(alu_z0)
  );

  gcd_lcm_ctrl #(.WIDTH(32), .MAX_ITER(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
    .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1), .result(result1),
    .err(err1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_y(alu_y1), .alu_z(alu_z1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: Euclid with remainders; subtraction steps = sum of quotients - 1.
  // LCM stepping takes (L/a - 1) + (L/b - 1) steps. Timeout after max_iter steps.
  task automatic ref_model(input logic md, input logic [31:0] a, input logic [31:0] b,
                           input int max_iter, output logic [31:0] res,
                           output logic e, output int lat);
    longint p, q, r, steps, n, l;
    if (a == 0 || b == 0) begin
      res = md ? 32'd0 : (a | b);
      e   = 1'b0;
      lat = 2;
    end else begin
      p = (a > b) ? longint'(a) : longint'(b);
      q = (a > b) ? longint'(b) : longint'(a);
      steps = 0;
      while (q != 0) begin
        steps += p / q;
        r = p % q;
        p = q;
        q = r;
      end
      if (!md) begin
        n   = steps - 1;
        res = 32'(p);
      end else begin
        l   = (longint'(a) / p) * longint'(b);
        n   = l / longint'(a) + l / longint'(b) - 2;
        res = 32'(l);
      end
      if (n >= max_iter) begin
        res = 32'd0;
        e   = 1'b1;
        lat = 3 * max_iter + 2;
      end else begin
        e   = 1'b0;
        lat = 3 * int'(n) + 3;
      end
    end
  endtask

  // Start is driven at the negedge of cycle 0; cycle c is sampled at its negedge.
  task automatic do_op(input logic dsel, input logic md, input logic [31:0] a,
                       input logic [31:0] b, input int poke, output logic [31:0] res,
                       output logic e, output int lat, output logic busy_ok);
    @(negedge clk);
    chk("idle_busy", dsel ? busy1 : busy0, 32'd0);
    mode = md;
    op_a = a;
    op_b = b;
    if (dsel) start1 = 1'b1; else start0 = 1'b1;
    lat = -1;
    res = '0;
    e = 1'b0;
    busy_ok = 1'b1;
    trace_q.delete();
    for (int c = 1; c <= 20000; c++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      @(negedge clk);
      if (c == poke) begin
        op_a = 32'd100;
        op_b = 32'd5;
        mode = ~md;
        if (dsel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (!dsel) trace_q.push_back(alu_op0);
      if (!(dsel ? busy1 : busy0)) busy_ok = 1'b0;
      if (dsel ? done1 : done0) begin
        lat = c;
        res = dsel ? result1 : result0;
        e   = dsel ? err1 : err0;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  typedef struct {
    logic        dsel;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] res, exp_res, ra, rb;
    logic        e, exp_e, busy_ok, saw_done, md;
    int          lat, exp_lat;
    logic [2:0]  exp_trace[9];

    vecs[0] = '{1'b0, 1'b0, 32'd12, 32'd8, 32'd4, 1'b0, 9};
    vecs[1] = '{1'b0, 1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 12};
    vecs[2] = '{1'b0, 1'b0, 32'd0, 32'd9, 32'd9, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd9, 32'd0, 1'b0, 2};
    vecs[4] = '{1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b1, 5};
    vecs[6] = '{1'b0, 1'b1, 32'd5, 32'd5, 32'd5, 1'b0, 3};
    vecs[7] = '{1'b0, 1'b0, 32'd21, 32'd14, 32'd7, 1'b0, 9};
    vecs[8] = '{1'b1, 1'b1, 32'd7, 32'd5, 32'd0, 1'b1, 14};
    vecs[9] = '{1'b1, 1'b0, 32'd9, 32'd6, 32'd3, 1'b0, 9};
    exp_trace = '{3'b000, 3'b001, 3'b101, 3'b001, 3'b001, 3'b101, 3'b001, 3'b001, 3'b000};

    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    mode    = 1'b0;
    op_a    = '0;
    op_b    = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy0, 32'd0);
    chk("reset_done", done0, 32'd0);
    chk("reset_result", result0, 32'd0);
    chk("reset_err", err0, 32'd0);
    chk("reset_alu_op", alu_op0, 32'd0);
    chk("reset_alu_a", alu_a0, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].dsel, vecs[i].md, vecs[i].a, vecs[i].b, 0, res, e, lat, busy_ok);
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_err", i), e, vecs[i].e);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), busy_ok, 32'd1);
      if (i == 0) begin
        chk("gcd12_8_trace_len", trace_q.size(), 32'd9);
        for (int k = 0; k < 9 && k < trace_q.size(); k++)
          chk($sformatf("gcd12_8_alu_op_c%0d", k + 1), trace_q[k], exp_trace[k]);
      end
    end

    // A start pulsed mid-operation must not disturb the running GCD(12,8).
    do_op(1'b0, 1'b0, 32'd12, 32'd8, 3, res, e, lat, busy_ok);
    chk("busy_start_result", res, 32'd4);
    chk("busy_start_latency", lat, 32'd9);
    chk("busy_start_err", e, 32'd0);

    // Reset during the LT cycle of GCD(12,8): everything clears, no done.
    @(negedge clk);
    mode = 1'b0;
    op_a = 32'd12;
    op_b = 32'd8;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_lt_op", alu_op0, 32'd5);
    reset_n = 1'b0;
    #1;
    chk("midop_reset_busy", busy0, 32'd0);
    chk("midop_reset_done", done0, 32'd0);
    chk("midop_reset_result", result0, 32'd0);
    chk("midop_reset_err", err0, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1'b1;
    end
    chk("no_done_after_reset", saw_done, 32'd0);
    do_op(1'b0, 1'b0, 32'd21, 32'd14, 0, res, e, lat, busy_ok);
    chk("post_reset_gcd_result", res, 32'd7);
    chk("post_reset_gcd_latency", lat, 32'd9);

    for (int i = 0; i < 40; i++) begin
      md = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      ref_model(md, ra, rb, 65535, exp_res, exp_e, exp_lat);
      do_op(1'b0, md, ra, rb, 0, res, e, lat, busy_ok);
      chk($sformatf("rand%0d_m%0d_%0d_%0d_result", i, md, ra, rb), res, exp_res);
      chk($sformatf("rand%0d_err", i), e, exp_e);
      chk($sformatf("rand%0d_latency", i), lat, exp_lat);
    end

    for (int i = 0; i < 6; i++) begin
      md = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(1, 12));
      rb = 32'($urandom_range(1, 12));
      ref_model(md, ra, rb, 4, exp_res, exp_e, exp_lat);
      do_op(1'b1, md, ra, rb, 0, res, e, lat, busy_ok);
      chk($sformatf("short%0d_m%0d_%0d_%0d_result", i, md, ra, rb), res, exp_res);
      chk($sformatf("short%0d_err", i), e, exp_e);
      chk($sformatf("short%0d_latency", i), lat, exp_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
